// File: rtl/rv_mmio_monitor.sv
// MMIO test-harness peripheral on the picorv32 native bus: tohost exit
// register, console byte FIFO drained over valid/ready, free-running cycle
// counter and a watchdog.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request in the window
// STALL | console push pending while the FIFO is full
// ACK   | one-cycle acknowledge; read data is presented
module rv_mmio_monitor #(
  parameter logic [31:0] MMIO_BASE      = 32'h1000_0000,
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mmio_sel,
  output logic        mmio_ready,
  output logic [31:0] mmio_rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        done,
  output logic [30:0] exit_code,
  output logic        timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_STALL, S_ACK} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [31:0]   cycle_cnt;
  logic [31:0]   wd_cnt;
  logic [31:0]   rd_data;
  logic [31:0]   status;
  logic          fifo_full, fifo_empty;
  logic          is_write, console_push, tohost_set;
  logic          push, pop, take, done_set;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^mem_addr[1:0];

  assign mmio_sel     = mem_valid && (mem_addr[31:4] == MMIO_BASE[31:4]);
  assign mmio_ready   = (state == S_ACK);
  assign fifo_full    = (count == CW'(FIFO_DEPTH));
  assign fifo_empty   = (count == '0);
  assign tx_valid     = !fifo_empty;
  assign tx_data      = tx_valid ? mem[rd_ptr] : 8'h00;
  assign pop          = tx_valid && tx_ready;

  // Instruction fetches never cause side effects, so they are masked out here.
  assign is_write     = |mem_wstrb;
  assign console_push = !mem_instr && (mem_addr[3:2] == 2'd1) && mem_wstrb[0];
  assign tohost_set   = !mem_instr && (mem_addr[3:2] == 2'd0) && is_write &&
                        mem_wdata[0] && !done;
  assign done_set     = take && (state == S_IDLE) && tohost_set;

  // Status word and read-data mux; writes and fetches return zero.
  always_comb begin
    status       = 32'h0;
    status[0]    = done;
    status[1]    = timeout;
    status[2]    = fifo_full;
    status[3]    = fifo_empty;
    status[15:8] = 8'(count);
    rd_data      = 32'h0;
    if (!mem_instr && !is_write) begin
      case (mem_addr[3:2])
        2'd0:    rd_data = {exit_code, done};
        2'd2:    rd_data = status;
        2'd3:    rd_data = cycle_cnt;
        default: rd_data = 32'h0;
      endcase
    end
  end

  // Next-state logic; take marks the edge that commits an access and loads read data.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    take      = 1'b0;
    case (state)
      S_IDLE: begin
        if (mmio_sel && !mmio_ready) begin
          if (console_push && fifo_full) begin
            state_nxt = S_STALL;
          end else begin
            state_nxt = S_ACK;
            take      = 1'b1;
            push      = console_push;
          end
        end
      end
      S_STALL: begin
        if (!mmio_sel) begin
          state_nxt = S_IDLE;
        end else if (!fifo_full) begin
          state_nxt = S_ACK;
          take      = 1'b1;
          push      = 1'b1;
        end
      end
      S_ACK:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // FIFO pointers and occupancy; push and pop in the same cycle leave count unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, tx_data is gated when empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= mem_wdata[7:0];
  end

  // Tohost latch and registered read data (zero outside the ack cycle).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      done       <= 1'b0;
      exit_code  <= '0;
      mmio_rdata <= '0;
    end else begin
      if (done_set) begin
        done      <= 1'b1;
        exit_code <= mem_wdata[31:1];
      end
      mmio_rdata <= take ? rd_data : 32'h0;
    end
  end

  // Cycle counter and watchdog; a tohost write on the expiry edge suppresses timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cycle_cnt <= '0;
      wd_cnt    <= '0;
      timeout   <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if ((TIMEOUT_CYCLES != 32'd0) && !done && !timeout) begin
        wd_cnt <= wd_cnt + 32'd1;
        if ((wd_cnt == TIMEOUT_CYCLES - 32'd1) && !done_set) timeout <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rv_mmio_monitor.md
# rv_mmio_monitor

Memory-mapped test-harness peripheral on the picorv32 native memory bus, in parallel with the RAM model. It decodes a 16-byte MMIO window and provides a tohost register (pass/fail exit), a console byte FIFO drained over a valid/ready stream, a free-running cycle counter and a watchdog. It ends compliance runs deterministically without relying on trap or PC-range heuristics.

## Interface
- `MMIO_BASE`, default 32'h1000_0000: window base; bits [3:0] ignored.
- `FIFO_DEPTH`, default 16: console FIFO depth; power of 2, 2..128.
- `TIMEOUT_CYCLES`, default 32'd1_000_000: watchdog limit; 0 disables the watchdog.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `mem_valid` in 1: core request valid.
- `mem_instr` in 1: request is an instruction fetch.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte strobes; 0 means read.
- `mmio_sel` out 1: combinational; `mem_valid && mem_addr[31:4]==MMIO_BASE[31:4]`. The RAM model must not respond when this is high.
- `mmio_ready` out 1: one-cycle acknowledge pulse.
- `mmio_rdata` out 32: read data, valid while `mmio_ready` is high.
- `tx_valid` out 1: console FIFO not empty.
- `tx_data` out 8: FIFO head byte.
- `tx_ready` in 1: sink accepts the byte when `tx_valid && tx_ready`.
- `done` out 1: sticky; tohost written with bit0=1.
- `exit_code` out 31: `mem_wdata[31:1]` of the first accepted tohost write.
- `timeout` out 1: sticky; watchdog expired.

## Operation
Register map (offset = `mem_addr[3:2]`):
- 0x0 TOHOST
  - Write with `wstrb!=0` and `wdata[0]=1`, while `done=0`: set `done`, latch `exit_code`.
  - Write with `wdata[0]=0`, or any write after `done`: acked, no effect.
  - Read returns `{exit_code, done}`.
- 0x4 CONSOLE
  - Write with `wstrb[0]=1` pushes `wdata[7:0]`.
  - Write with `wstrb[0]=0` is acked with no push.
  - Read returns 0.
- 0x8 STATUS (read-only): bit0 `done`, bit1 `timeout`, bit2 full, bit3 empty, [15:8] FIFO count, other bits 0.
- 0xC CYCLE (read-only): 32-bit cycle counter. It increments every cycle from reset and wraps at 2^32.
- Writes to STATUS and CYCLE are acked and ignored. Instruction fetches (`mem_instr=1`) in the window are acked with rdata 0 and no side effect.

FSM:
- IDLE
  - `mmio_sel && !mmio_ready` and the access is a CONSOLE push with FIFO full → STALL.
  - Otherwise → ACK, performing the side effect on that edge.
- STALL
  - FIFO count < `FIFO_DEPTH` (registered) → ACK with push.
  - `mmio_sel` low → IDLE, no push, no ack.
- ACK: `mmio_ready=1` for exactly one cycle → IDLE. A request is never acked twice.

FIFO:
- Circular buffer with wrapping read/write pointers and a count of width clog2(DEPTH)+1.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Pop never occurs when empty. Push never occurs when full, because the FSM stalls instead.

Watchdog:
- Counts cycles while `done=0 && timeout=0`.
- Sets `timeout` when the count reaches `TIMEOUT_CYCLES`, then freezes.
- Never sets if `TIMEOUT_CYCLES=0`.
- If `done` and expiry happen on the same edge, `done` wins: `timeout` stays 0.

## Timing
- Reset (async assert; release synchronous to `clk`):
  - `mmio_ready`, `mmio_rdata`, `tx_valid`, `tx_data`, `done`, `exit_code`, `timeout` all 0.
  - FIFO empty, both counters 0, FSM IDLE.
  - Reset mid-transaction abandons it with no ack.
- `mmio_sel` is combinational, same cycle as `mem_valid`.
- Latency with no stall: `mmio_sel` high at cycle N → `mmio_ready` high during N+1, low at N+2. `done`/`exit_code`/push are visible from N+1.
- Latency with a full-FIFO stall: ack one cycle after the FIFO count first drops below DEPTH.
- STATUS and CYCLE reads return values sampled at the edge ending cycle N.
- `tx_valid` rises the cycle after the first push into an empty FIFO.

## Test plan
- Reset: assert `resetn=0` mid-STALL → all outputs 0, `tx_valid=0`, no ack. After release, a CYCLE read at cycle 5 returns 4 or 5, the same value on every run.
- Tohost: write 0x0000_0001 to 0x1000_0000 → `mmio_ready` pulses at N+1, `done=1`, `exit_code=0`. A later write of 0x0000_0007 leaves `exit_code=0`. A first write of 0x0000_0006 leaves `done=0`.
- Console: write 0x41, 0x42, 0x43 to 0x1000_0004 with `tx_ready=1` → `tx_data` shows 0x41, 0x42, 0x43 in order, then `tx_valid=0`. Write with `wstrb=4'b0010` → no push.
- FIFO full: `tx_ready=0`, 16 pushes, then a 17th → no `mmio_ready` while stalled. Pulse `tx_ready` once → ack 2 cycles later, count=16, 0x41 popped first.
- Wrap and simultaneous: `tx_ready=1` with back-to-back pushes for 40 bytes → all 40 received in order, count never exceeds 1.
- Watchdog: `TIMEOUT_CYCLES=100`, no tohost write → `timeout=1` by cycle 101, STATUS bit1=1. Tohost written at the exact expiry cycle → `done=1`, `timeout=0`.
